// File: rtl/nbit_mosi_spi_rx_buffer.sv
// MOSI SPI receive buffer: deserializes i_MOSI/i_CS/i_DC into MSB-first words
// and packs up to N words plus their D/C flags into a frame buffer.
//
// Ports:
//   i_SCK, i_RST         clock, synchronous active-high reset
//   i_MOSI, i_CS, i_DC   serial data, active-low chip select, data/command flag
//   o_BYTE, o_BYTE_DC    last completed word and its D/C flag
//   o_BYTE_VALID         one-cycle pulse when o_BYTE/o_BYTE_DC update
//   o_DATA, o_DC         frame buffer (slot k at [WIDTH*k +: WIDTH]) and D/C bits
//   o_COUNT              words stored in the current/last frame (saturates at N)
//   o_FRAME_DONE         one-cycle pulse after i_CS rises
//   o_PARTIAL            last frame ended mid-word
//   o_OVERFLOW           more than N words arrived in this frame
module nbit_mosi_spi_rx_buffer #(
    parameter int WIDTH = 8,
    parameter int N     = 8
) (
    input  logic                   i_SCK,
    input  logic                   i_RST,
    input  logic                   i_MOSI,
    input  logic                   i_CS,
    input  logic                   i_DC,
    output logic [WIDTH-1:0]       o_BYTE,
    output logic                   o_BYTE_DC,
    output logic                   o_BYTE_VALID,
    output logic [WIDTH*N-1:0]     o_DATA,
    output logic [N-1:0]           o_DC,
    output logic [$clog2(N+1)-1:0] o_COUNT,
    output logic                   o_FRAME_DONE,
    output logic                   o_PARTIAL,
    output logic                   o_OVERFLOW
);

    localparam int CW = $clog2(N+1);
    localparam int BW = (WIDTH > 1) ? $clog2(WIDTH) : 1;
    localparam int SW = (N > 1) ? $clog2(N) : 1;

    typedef enum logic [1:0] {
        S_IDLE = 2'd0,
        S_RECV = 2'd1,
        S_DONE = 2'd2
    } state_t;

    state_t           r_state;
    logic [WIDTH-1:0] r_shift;
    logic [BW-1:0]    r_bitcnt;

    logic             w_start;
    logic [BW-1:0]    w_bit_idx;
    logic             w_word_end;
    logic [WIDTH-1:0] w_word;
    logic [CW-1:0]    w_slot_count;
    logic [SW-1:0]    w_slot;

    // A frame start samples its first bit in the same cycle, so the bit index
    // and the slot count are taken as already cleared when w_start is high.
    always_comb begin
        w_start      = (r_state != S_RECV) && !i_CS;
        w_bit_idx    = w_start ? '0 : r_bitcnt;
        w_word_end   = !i_CS && (w_bit_idx == BW'(WIDTH-1));
        w_word       = {r_shift[WIDTH-2:0], i_MOSI};
        w_slot_count = w_start ? '0 : o_COUNT;
        w_slot       = w_slot_count[SW-1:0];
    end

    always_ff @(posedge i_SCK) begin
        if (i_RST) begin
            r_state      <= S_IDLE;
            r_shift      <= '0;
            r_bitcnt     <= '0;
            o_BYTE       <= '0;
            o_BYTE_DC    <= 1'b0;
            o_BYTE_VALID <= 1'b0;
            o_DATA       <= '0;
            o_DC         <= '0;
            o_COUNT      <= '0;
            o_FRAME_DONE <= 1'b0;
            o_PARTIAL    <= 1'b0;
            o_OVERFLOW   <= 1'b0;
        end else begin
            o_BYTE_VALID <= 1'b0;
            o_FRAME_DONE <= 1'b0;

            unique case (r_state)
                S_IDLE: begin
                    if (!i_CS) r_state <= S_RECV;
                end
                S_RECV: begin
                    if (i_CS) begin
                        r_state      <= S_DONE;
                        o_FRAME_DONE <= 1'b1;
                        o_PARTIAL    <= (r_bitcnt != '0);
                    end
                end
                S_DONE: begin
                    r_state <= i_CS ? S_IDLE : S_RECV;
                end
                default: r_state <= S_IDLE;
            endcase

            if (w_start) begin
                o_DATA     <= '0;
                o_DC       <= '0;
                o_COUNT    <= '0;
                o_PARTIAL  <= 1'b0;
                o_OVERFLOW <= 1'b0;
            end

            // Bits are only sampled while CS is low; a CS-high cycle drops
            // any partially assembled word.
            if (!i_CS) begin
                r_shift  <= w_word;
                r_bitcnt <= w_word_end ? '0 : w_bit_idx + BW'(1);
            end else begin
                r_bitcnt <= '0;
            end

            if (w_word_end) begin
                o_BYTE       <= w_word;
                o_BYTE_DC    <= i_DC;
                o_BYTE_VALID <= 1'b1;
                if (w_slot_count < CW'(N)) begin
                    o_DATA[WIDTH*w_slot +: WIDTH] <= w_word;
                    o_DC[w_slot]                  <= i_DC;
                    o_COUNT                       <= w_slot_count + CW'(1);
                end else begin
                    o_OVERFLOW <= 1'b1;
                end
            end
        end
    end

endmodule
